fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//  Round-robin write-port arbiter sharing one synchronous FIFO between NUM_REQ producers.
//  Grants one requester at a time for a burst of up to MAX_BURST words.
//  Drives the FIFO wr_en/data_in and uses full/almostfull so the FIFO never overflows.
//  Sits between the producer agents and the FIFO_Interface write side.
// PARAMETERS
//  NUM_REQ     4   number of requesters (2..8)
//  FIFO_WIDTH  16  data word width, matches FIFO data_in
//  MAX_BURST   4   max words per grant before rotation (>=1)
// PORTS
//  clk             in   1                    single clock, all logic on posedge
//  rst             in   1                    synchronous, active-high reset
//  req_valid       in   NUM_REQ              per-requester word valid
//  req_data        in   NUM_REQ*FIFO_WIDTH   packed words, requester i at [i*W +: W]
//  req_ready       out  NUM_REQ              per-requester accept (combinational)
//  fifo_full       in   1                    FIFO full flag
//  fifo_almostfull in   1                    FIFO one-slot-left flag
//  fifo_overflow   in   1                    FIFO overflow flag
//  fifo_wr_en      out  1                    registered write enable to FIFO
//  fifo_data_in    out  FIFO_WIDTH           registered write data to FIFO
//  grant_id        out  $clog2(NUM_REQ)      current owner index (valid when busy)
//  busy            out  1                    1 while in BURST state
//  err_overflow    out  1                    sticky: FIFO reported overflow
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=IDLE, rr_ptr=0, burst_cnt=0; all outputs 0. Mid-burst reset aborts the
//   burst; the held word is discarded.
//  FSM IDLE: if |req_valid, select the first valid index searching rr_ptr, rr_ptr+1, ... (mod NUM_REQ),
//   latch it as owner/grant_id, burst_cnt=0, go to BURST. No data moves in IDLE.
//  FSM BURST: req_ready[i] = (i==owner) && !fifo_full && !(fifo_almostfull && fifo_wr_en); all others 0.
//   A transfer happens when req_valid[owner] && req_ready[owner].
//  Transfer: next cycle fifo_wr_en=1 and fifo_data_in=req_data[owner]; otherwise fifo_wr_en=0 and
//   fifo_data_in holds its value. Latency from accepted word to FIFO write is 1 cycle.
//  burst_cnt increments on each transfer.
//  Exit BURST -> IDLE (rr_ptr=owner+1 mod NUM_REQ) when:
//   - a transfer occurs with burst_cnt==MAX_BURST-1, or
//   - req_valid[owner]==0.
//  Full stall: while fifo_full, or almostfull with a write in flight, the owner keeps the grant, no
//   transfer occurs and burst_cnt is frozen.
//  Rotation: each grant costs one IDLE bubble cycle, so a re-grant to the same requester needs a cycle in
//   IDLE. A sole active requester is re-granted after that bubble.
//  Simultaneous: several requesters valid in IDLE -> lowest index at or after rr_ptr wins.
//  err_overflow is set when fifo_overflow==1 at posedge and clears only on rst. It is never expected.
//  Widths: grant_id/rr_ptr are $clog2(NUM_REQ) bits with explicit mod wrap. burst_cnt is
//   $clog2(MAX_BURST+1) bits.
// STRUCTURE
//  SHARED_PKG: typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_e; localparam defaults for
//   NUM_REQ/MAX_BURST.
//  Sub-module rr_priority_picker (NUM_REQ): combinational req_valid + rr_ptr -> found, index.
//  Top holds the FSM, counters and output registers.
// TESTING
//  1. Reset mid-burst: rst=1 during BURST -> next cycle busy=0, fifo_wr_en=0, req_ready=0, grant_id=0.
//  2. Only req2 valid with 6 words, FIFO empty, MAX_BURST=4 -> 4 writes, 1 IDLE cycle, then 2 writes.
//     Data order is preserved; fifo_wr_en follows each accept by 1 cycle.
//  3. All 4 requesters continuously valid -> grant order 0,1,2,3,0...; each gets 4 words; no requester
//     gets 2 grants in a row.
//  4. Fill to almostfull with req0 writing -> req_ready drops when almostfull and a write is in flight.
//     FIFO reaches exactly full; fifo_overflow never asserts; err_overflow stays 0.
//  5. Full then one read -> owner stalls with burst_cnt frozen, resumes after full deasserts, and
//     completes its remaining burst words.
//  6. Owner drops valid after 1 word -> BURST exits next edge; rr_ptr=owner+1; the next valid requester
//     is granted.

Source files
------------

// File: rtl/fifo_wr_arbiter_pkg.sv
// ============================================================================
// Module   : fifo_wr_arbiter_pkg
// Purpose  : Shared types, defaults and index helpers for the FIFO write arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_wr_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_e;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_FIFO_WIDTH = 16;
  localparam int DEF_MAX_BURST  = 4;

  // Index width that stays at least one bit wide for degenerate counts.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_wr_arbiter_if.sv
// ============================================================================
// Module   : fifo_wr_arbiter_if
// Purpose  : Producer-side and FIFO-write-side signals of the write arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fifo_wr_arbiter_if
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int FIFO_WIDTH = DEF_FIFO_WIDTH
);
  localparam int GRANT_W = idx_width(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_full;
  logic                          fifo_almostfull;
  logic                          fifo_overflow;
  logic                          fifo_wr_en;
  logic [FIFO_WIDTH-1:0]         fifo_data_in;
  logic [GRANT_W-1:0]            grant_id;
  logic                          busy;
  logic                          err_overflow;

  modport master (
    output req_valid, req_data, fifo_full, fifo_almostfull, fifo_overflow,
    input  req_ready, fifo_wr_en, fifo_data_in, grant_id, busy, err_overflow
  );

  modport slave (
    input  req_valid, req_data, fifo_full, fifo_almostfull, fifo_overflow,
    output req_ready, fifo_wr_en, fifo_data_in, grant_id, busy, err_overflow
  );

endinterface

`default_nettype wire

// File: rtl/fifo_wr_arbiter_rr_priority_picker.sv
// ============================================================================
// Module   : rr_priority_picker
// Purpose  : First valid requester at or after the start index, wrapping mod NUM_REQ.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_priority_picker
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = idx_width(DEF_NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   start,
  output logic               found,
  output logic [IDX_W-1:0]   index
);

  assign found = |valid;

  // Walk offsets from farthest to nearest so the nearest valid index wins.
  always_comb begin
    index = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      int c;
      c = int'(start) + k;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      if (valid[IDX_W'(c)]) index = IDX_W'(c);
    end
  end

endmodule

`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
// ============================================================================
// Module   : fifo_wr_arbiter
// Purpose  : Round-robin burst arbiter sharing one FIFO write port among producers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter int MAX_BURST  = DEF_MAX_BURST
) (
  input  logic             clk,
  input  logic             rst,
  fifo_wr_arbiter_if.slave bus
);

  localparam int IDX_W = idx_width(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] c_last_beat = CNT_W'(MAX_BURST - 1);

  arb_state_e             r_state;
  arb_state_e             w_state_nxt;
  logic [IDX_W-1:0]       r_owner;
  logic [IDX_W-1:0]       r_rr_ptr;
  logic [CNT_W-1:0]       r_burst_cnt;
  logic                   r_wr_en;
  logic [FIFO_WIDTH-1:0]  r_data;
  logic                   r_err;

  logic                   w_found;
  logic [IDX_W-1:0]       w_pick;
  logic [IDX_W-1:0]       w_rr_next;
  logic                   w_can_accept;
  logic                   w_owner_valid;
  logic                   w_xfer;
  logic                   w_exit;
  logic [NUM_REQ-1:0]     w_ready;
  logic [FIFO_WIDTH-1:0]  w_words [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_words[gi] = bus.req_data[gi*FIFO_WIDTH +: FIFO_WIDTH];
    end
  endgenerate

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .valid (bus.req_valid),
    .start (r_rr_ptr),
    .found (w_found),
    .index (w_pick)
  );

  // A write already in flight will consume the last free slot.
  assign w_can_accept  = (r_state == ARB_BURST) && !bus.fifo_full &&
                         !(bus.fifo_almostfull && r_wr_en);
  assign w_owner_valid = bus.req_valid[r_owner];
  assign w_xfer        = w_owner_valid && w_can_accept;
  assign w_rr_next     = IDX_W'(rr_next(int'(r_owner), NUM_REQ));

  always_comb begin
    w_ready = '0;
    if (w_can_accept) w_ready[r_owner] = 1'b1;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_exit      = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (w_found) w_state_nxt = ARB_BURST;
      end
      ARB_BURST: begin
        if (!w_owner_valid || (w_xfer && (r_burst_cnt == c_last_beat))) begin
          w_state_nxt = ARB_IDLE;
          w_exit      = 1'b1;
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ARB_IDLE;
      r_owner     <= '0;
      r_rr_ptr    <= '0;
      r_burst_cnt <= '0;
      r_wr_en     <= 1'b0;
      r_data      <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wr_en <= w_xfer;
      if (w_xfer) r_data <= w_words[r_owner];
      if (bus.fifo_overflow) r_err <= 1'b1;
      if ((r_state == ARB_IDLE) && w_found) begin
        r_owner     <= w_pick;
        r_burst_cnt <= '0;
      end else if (w_xfer) begin
        r_burst_cnt <= r_burst_cnt + 1'b1;
      end
      if (w_exit) r_rr_ptr <= w_rr_next;
    end
  end

  assign bus.req_ready    = w_ready;
  assign bus.fifo_wr_en   = r_wr_en;
  assign bus.fifo_data_in = r_data;
  assign bus.grant_id     = r_owner;
  assign bus.busy         = (r_state == ARB_BURST);
  assign bus.err_overflow = r_err;

endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
// ============================================================================
// Module   : tb_fifo_wr_arbiter
// Purpose  : Self-checking bench: producer models, FIFO model and write scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_wr_arbiter;
  import fifo_wr_arbiter_pkg::*;

  localparam int NUM_REQ    = 4;
  localparam int FIFO_WIDTH = 16;
  localparam int MAX_BURST  = 4;
  localparam int DEPTH      = 8;
  localparam int MAXG       = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NUM_REQ(NUM_REQ), .FIFO_WIDTH(FIFO_WIDTH)) bus ();

  fifo_wr_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .FIFO_WIDTH (FIFO_WIDTH),
    .MAX_BURST  (MAX_BURST)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // FIFO model: flags derive from an occupancy counter updated on the clock.
  int   fcount;
  int   preload   = 0;
  logic rd_en     = 1'b0;
  logic force_ovf = 1'b0;
  logic model_ovf;
  logic rd_go;
  logic rst_seen;

  assign rd_go                = rd_en && (fcount != 0);
  assign bus.fifo_full        = (fcount == DEPTH);
  assign bus.fifo_almostfull  = (fcount == DEPTH - 1);
  assign bus.fifo_overflow    = model_ovf | force_ovf;

  always @(posedge clk) begin
    rst_seen <= rst;
    if (rst) begin
      fcount    <= preload;
      model_ovf <= 1'b0;
    end else begin
      model_ovf <= bus.fifo_wr_en && !rd_go && (fcount == DEPTH);
      if (bus.fifo_wr_en && !rd_go && (fcount < DEPTH)) fcount <= fcount + 1;
      else if (rd_go && !bus.fifo_wr_en) fcount <= fcount - 1;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  int remaining [NUM_REQ];
  int seq       [NUM_REQ];
  logic                ovr_en   = 1'b0;
  logic [NUM_REQ-1:0]  ovr_mask = '0;
  logic                exp_wr   = 1'b0;
  logic [FIFO_WIDTH-1:0] sb [$];

  int g_id [MAXG];
  int g_words [MAXG];
  int g_cycles [MAXG];
  int g_idle [MAXG];
  int n_g = 0;
  int idle_run = 0;
  logic prev_busy = 1'b0;

  typedef struct {
    logic [NUM_REQ-1:0] mask;
    logic               exp_busy;
    int                 exp_grant;
  } pick_vec_t;

  pick_vec_t vecs [10];

  function automatic logic [FIFO_WIDTH-1:0] word_of(input int i, input int s);
    logic [FIFO_WIDTH-1:0] w;
    w = {i[3:0], s[11:0]};
    return w;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [FIFO_WIDTH-1:0] exp_d;
    if (rst_seen) begin
      sb.delete();
      exp_wr = 1'b0;
    end
    check("wr_en_latency", int'(bus.fifo_wr_en), int'(exp_wr));
    if (bus.fifo_wr_en) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_empty: write of %0h with no accepted word at %0t",
                 bus.fifo_data_in, $time);
      end else begin
        exp_d = sb.pop_front();
        check("wr_data", int'(bus.fifo_data_in), int'(exp_d));
      end
    end
    exp_wr = 1'b0;
    if (!force_ovf) check("no_overflow", int'(bus.fifo_overflow), 0);
    check("ready_onehot", int'($countones(bus.req_ready) <= 1), 1);
    if (bus.busy) begin
      if (!prev_busy && (n_g < MAXG)) begin
        g_id[n_g]     = int'(bus.grant_id);
        g_words[n_g]  = 0;
        g_cycles[n_g] = 0;
        g_idle[n_g]   = idle_run;
        n_g++;
      end
      if (n_g > 0) g_cycles[n_g-1]++;
      idle_run = 0;
    end else begin
      idle_run++;
    end
    prev_busy = bus.busy;
  endtask

  task automatic drive_inputs();
    logic [NUM_REQ-1:0]            v;
    logic [NUM_REQ*FIFO_WIDTH-1:0] d;
    logic [NUM_REQ-1:0]            acc;
    for (int i = 0; i < NUM_REQ; i++) begin
      v[i] = ovr_en ? ovr_mask[i] : (remaining[i] > 0);
      d[i*FIFO_WIDTH +: FIFO_WIDTH] = word_of(i, seq[i]);
    end
    ovr_mask      = '0;
    bus.req_valid = v;
    bus.req_data  = d;
    acc = v & bus.req_ready;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (acc[i]) begin
        sb.push_back(word_of(i, seq[i]));
        seq[i]++;
        remaining[i]--;
        exp_wr = 1'b1;
        if (n_g > 0) g_words[n_g-1]++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
    drive_inputs();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      remaining[i] = 0;
      seq[i]       = 0;
    end
    tick();
    tick();
    rst       = 1'b0;
    n_g       = 0;
    idle_run  = 0;
    prev_busy = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && (n < budget)) begin
      tick();
      n++;
      done = !bus.busy && (sb.size() == 0) && !bus.fifo_wr_en;
      for (int i = 0; i < NUM_REQ; i++) if (remaining[i] > 0) done = 1'b0;
    end
    check({name, "_done_in_budget"}, int'(done), 1);
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    vecs[0] = '{4'b0001, 1'b1, 0};
    vecs[1] = '{4'b0001, 1'b1, 0};
    vecs[2] = '{4'b1010, 1'b1, 1};
    vecs[3] = '{4'b1011, 1'b1, 3};
    vecs[4] = '{4'b1100, 1'b1, 2};
    vecs[5] = '{4'b0111, 1'b1, 0};
    vecs[6] = '{4'b1111, 1'b1, 1};
    vecs[7] = '{4'b0010, 1'b1, 1};
    vecs[8] = '{4'b0000, 1'b0, 0};
    vecs[9] = '{4'b1001, 1'b1, 3};

    do_reset();
    check("rst_busy", int'(bus.busy), 0);
    check("rst_wr_en", int'(bus.fifo_wr_en), 0);
    check("rst_ready", int'(bus.req_ready), 0);
    check("rst_grant", int'(bus.grant_id), 0);
    check("rst_err", int'(bus.err_overflow), 0);
    check("rst_data", int'(bus.fifo_data_in), 0);

    // Round-robin pick table: grant for one cycle, then drop valid to release.
    ovr_en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      ovr_mask = vecs[k].mask;
      tick();
      tick();
      check($sformatf("pick%0d_busy", k), int'(bus.busy), int'(vecs[k].exp_busy));
      if (vecs[k].exp_busy)
        check($sformatf("pick%0d_grant", k), int'(bus.grant_id), vecs[k].exp_grant);
      tick();
      check($sformatf("pick%0d_release", k), int'(bus.busy), 0);
    end
    ovr_en = 1'b0;

    // Reset in the middle of a burst.
    do_reset();
    rd_en = 1'b1;
    remaining[0] = 10;
    tick();
    tick();
    tick();
    check("t1_busy_before", int'(bus.busy), 1);
    rst = 1'b1;
    remaining[0] = 0;
    tick();
    rst = 1'b0;
    check("t1_busy", int'(bus.busy), 0);
    check("t1_wr_en", int'(bus.fifo_wr_en), 0);
    check("t1_ready", int'(bus.req_ready), 0);
    check("t1_grant", int'(bus.grant_id), 0);

    // Single requester, six words: 4-word burst, bubble, then 2 words.
    do_reset();
    rd_en = 1'b0;
    remaining[2] = 6;
    wait_done(40, "t2");
    check("t2_ngrants", n_g, 2);
    check("t2_id0", g_id[0], 2);
    check("t2_id1", g_id[1], 2);
    check("t2_words0", g_words[0], 4);
    check("t2_words1", g_words[1], 2);
    check("t2_cycles0", g_cycles[0], 4);
    check("t2_bubble", g_idle[1], 1);
    check("t2_fcount", fcount, 6);

    // All requesters continuously valid.
    do_reset();
    rd_en = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) remaining[i] = 8;
    wait_done(200, "t3");
    check("t3_ngrants", n_g, 8);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("t3_id%0d", k), g_id[k], k % NUM_REQ);
      check($sformatf("t3_words%0d", k), g_words[k], MAX_BURST);
    end

    // Fill to full with one producer; the in-flight write blocks the last slot.
    begin
      int saw;
      saw = 0;
      preload = 1;
      do_reset();
      rd_en = 1'b0;
      remaining[0] = 12;
      for (int n = 0; n < 40; n++) begin
        tick();
        if (bus.busy && bus.fifo_almostfull && bus.fifo_wr_en) begin
          saw++;
          check("t4_ready_drop", int'(bus.req_ready), 0);
        end
      end
      check("t4_af_inflight_seen", int'(saw > 0), 1);
      check("t4_fcount_full", fcount, DEPTH);
      check("t4_left", remaining[0], 5);
      check("t4_err", int'(bus.err_overflow), 0);
      check("t4_owner_holds", int'(bus.busy), 1);
    end

    // Stall mid-burst at full, single read, then drain.
    preload = 6;
    do_reset();
    preload = 0;
    remaining[0] = 4;
    for (int n = 0; n < 6; n++) tick();
    check("t5_stall_busy", int'(bus.busy), 1);
    check("t5_stall_ready", int'(bus.req_ready), 0);
    check("t5_stall_left", remaining[0], 2);
    check("t5_full", fcount, DEPTH);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    for (int n = 0; n < 4; n++) tick();
    check("t5_one_more", remaining[0], 1);
    check("t5_still_owner", int'(bus.busy), 1);
    rd_en = 1'b1;
    wait_done(40, "t5");
    check("t5_ngrants", n_g, 1);
    check("t5_words", g_words[0], MAX_BURST);
    check("t5_err", int'(bus.err_overflow), 0);

    // Owner drops valid after one word; rotation continues past it.
    begin
      int n;
      do_reset();
      rd_en = 1'b1;
      remaining[1] = 1;
      n = 0;
      while (!bus.busy && n < 10) begin
        tick();
        n++;
      end
      check("t6_granted", int'(bus.busy), 1);
      remaining[0] = 1;
      remaining[3] = 2;
      wait_done(40, "t6");
      check("t6_ngrants", n_g, 3);
      check("t6_id0", g_id[0], 1);
      check("t6_cycles0", g_cycles[0], 2);
      check("t6_id1", g_id[1], 3);
      check("t6_words1", g_words[1], 2);
      check("t6_id2", g_id[2], 0);
    end

    // Sticky overflow error.
    do_reset();
    force_ovf = 1'b1;
    tick();
    force_ovf = 1'b0;
    tick();
    check("ovf_set", int'(bus.err_overflow), 1);
    tick();
    tick();
    check("ovf_sticky", int'(bus.err_overflow), 1);
    do_reset();
    check("ovf_cleared", int'(bus.err_overflow), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
